axi_master_wrapper: RTL

- Core-side initiator that converts a simple single-outstanding request interface into AXI4 read and write bursts.
- Its AXI ports face the slave-side wrapper through the interconnect. One transaction is in flight at a time.
- Handles INCR bursts of 1..2^LEN_WIDTH beats at full data width, checks response ID/last/resp, and reports one completion per request.

---
 rtl/axi_pkg.sv | 38 +++
 rtl/axi_beat_counter.sv | 31 +++
 rtl/axi_master_wrapper.sv | 224 ++++++++++++++++++++++
 3 files changed

// File: rtl/axi_pkg.sv
// Shared types, AXI encodings and helper functions for the AXI master wrapper.
package axi_pkg;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_AR   = 3'd1,
        ST_R    = 3'd2,
        ST_AW   = 3'd3,
        ST_W    = 3'd4,
        ST_B    = 3'd5
    } state_t;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_EXOKAY = 2'b01;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] RESP_DECERR = 2'b11;

    localparam logic [1:0] BURST_INCR  = 2'b01;

    // The response encodings are ordered by severity, so the worse of two
    // responses is simply the numerically larger one.
    function automatic logic [1:0] resp_max(input logic [1:0] a, input logic [1:0] b);
        return (a > b) ? a : b;
    endfunction

    // AxSIZE encoding: log2 of the number of bytes per beat.
    function automatic logic [2:0] size_enc(input int bytes);
        logic [2:0] enc;
        enc = 3'd0;
        for (int i = 0; i < 8; i++) begin
            if ((1 << i) == bytes) begin
                enc = 3'(i);
            end
        end
        return enc;
    endfunction

endpackage

// File: rtl/axi_beat_counter.sv
// Beat counter shared by the read and write data phases; flags the final beat.
module axi_beat_counter
    import axi_pkg::*;
#(
    parameter int LEN_WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 clear,
    input  logic                 inc,
    input  logic [LEN_WIDTH-1:0] len,
    output logic                 is_last
);

    // One extra bit so a full 2^LEN_WIDTH burst never wraps the counter.
    logic [LEN_WIDTH:0] count;

    // Count data handshakes, restarting at zero when a new burst is accepted.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (inc) begin
            count <= count + 1'b1;
        end
    end

    assign is_last = (count == {1'b0, len});

endmodule

// File: rtl/axi_master_wrapper.sv
// Single-outstanding core request to AXI4 INCR burst master.
module axi_master_wrapper
    import axi_pkg::*;
#(
    parameter int                    ID_WIDTH   = 4,
    parameter int                    ADDR_WIDTH = 32,
    parameter int                    DATA_WIDTH = 32,
    parameter int                    LEN_WIDTH  = 8,
    parameter logic [ID_WIDTH-1:0]   MST_ID     = 4'd1
) (
    input  logic                      aclk,
    input  logic                      areset_n,

    input  logic                      req_valid,
    output logic                      req_ready,
    input  logic                      req_write,
    input  logic [ADDR_WIDTH-1:0]     req_addr,
    input  logic [LEN_WIDTH-1:0]      req_len,

    input  logic                      wd_valid,
    output logic                      wd_ready,
    input  logic [DATA_WIDTH-1:0]     wd_data,
    input  logic [DATA_WIDTH/8-1:0]   wd_strb,

    output logic                      rd_valid,
    input  logic                      rd_ready,
    output logic [DATA_WIDTH-1:0]     rd_data,
    output logic                      rd_last,

    output logic                      done_valid,
    output logic [1:0]                done_resp,

    output logic [ID_WIDTH-1:0]       awid,
    output logic [ADDR_WIDTH-1:0]     awaddr,
    output logic [LEN_WIDTH-1:0]      awlen,
    output logic [2:0]                awsize,
    output logic [1:0]                awburst,
    output logic                      awvalid,
    input  logic                      awready,

    output logic [DATA_WIDTH-1:0]     wdata,
    output logic [DATA_WIDTH/8-1:0]   wstrb,
    output logic                      wlast,
    output logic                      wvalid,
    input  logic                      wready,

    input  logic [ID_WIDTH-1:0]       bid,
    input  logic [1:0]                bresp,
    input  logic                      bvalid,
    output logic                      bready,

    output logic [ID_WIDTH-1:0]       arid,
    output logic [ADDR_WIDTH-1:0]     araddr,
    output logic [LEN_WIDTH-1:0]      arlen,
    output logic [2:0]                arsize,
    output logic [1:0]                arburst,
    output logic                      arvalid,
    input  logic                      arready,

    input  logic [ID_WIDTH-1:0]       rid,
    input  logic [DATA_WIDTH-1:0]     rdata,
    input  logic [1:0]                rresp,
    input  logic                      rlast,
    input  logic                      rvalid,
    output logic                      rready
);

    localparam logic [2:0] AXSIZE = size_enc(DATA_WIDTH / 8);

    state_t                state;
    logic [ADDR_WIDTH-1:0] addr_reg;
    logic [LEN_WIDTH-1:0]  len_reg;
    logic [1:0]            err_reg;

    logic                  accept;
    logic                  r_hs;
    logic                  w_hs;
    logic                  is_last;
    logic                  r_end;
    logic [1:0]            r_merged;
    logic [1:0]            b_merged;

    assign accept = (state == ST_IDLE) && req_ready && req_valid;
    assign r_hs   = (state == ST_R) && rvalid && rd_ready;
    assign w_hs   = (state == ST_W) && wd_valid && wready;

    // A read ends on the slave's rlast or on the expected last beat, whichever comes first.
    assign r_end  = rlast || is_last;

    axi_beat_counter #(
        .LEN_WIDTH (LEN_WIDTH)
    ) u_beat_counter (
        .clk     (aclk),
        .rst_n   (areset_n),
        .clear   (accept),
        .inc     (r_hs || w_hs),
        .len     (len_reg),
        .is_last (is_last)
    );

    // Fold the current R beat's response, ID check and rlast check into the running error.
    always_comb begin
        logic [1:0] beat_resp;
        beat_resp = rresp;
        if ((rid != MST_ID) || (rlast != is_last)) begin
            beat_resp = resp_max(beat_resp, RESP_SLVERR);
        end
        r_merged = resp_max(err_reg, beat_resp);
    end

    // Fold the B response and its ID check into the running error.
    always_comb begin
        logic [1:0] beat_resp;
        beat_resp = bresp;
        if (bid != MST_ID) begin
            beat_resp = resp_max(beat_resp, RESP_SLVERR);
        end
        b_merged = resp_max(err_reg, beat_resp);
    end

    // Transaction sequencer with registered handshake and completion outputs.
    always_ff @(posedge aclk) begin
        if (!areset_n) begin
            state      <= ST_IDLE;
            req_ready  <= 1'b0;
            awvalid    <= 1'b0;
            arvalid    <= 1'b0;
            bready     <= 1'b0;
            done_valid <= 1'b0;
            done_resp  <= RESP_OKAY;
            addr_reg   <= '0;
            len_reg    <= '0;
            err_reg    <= RESP_OKAY;
        end else begin
            done_valid <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (accept) begin
                        req_ready <= 1'b0;
                        addr_reg  <= req_addr;
                        len_reg   <= req_len;
                        err_reg   <= RESP_OKAY;
                        if (req_write) begin
                            awvalid <= 1'b1;
                            state   <= ST_AW;
                        end else begin
                            arvalid <= 1'b1;
                            state   <= ST_AR;
                        end
                    end else begin
                        req_ready <= 1'b1;
                    end
                end
                ST_AR: begin
                    if (arready) begin
                        arvalid <= 1'b0;
                        state   <= ST_R;
                    end
                end
                ST_R: begin
                    if (r_hs) begin
                        err_reg <= r_merged;
                        if (r_end) begin
                            done_valid <= 1'b1;
                            done_resp  <= r_merged;
                            state      <= ST_IDLE;
                        end
                    end
                end
                ST_AW: begin
                    if (awready) begin
                        awvalid <= 1'b0;
                        state   <= ST_W;
                    end
                end
                ST_W: begin
                    if (w_hs && is_last) begin
                        bready <= 1'b1;
                        state  <= ST_B;
                    end
                end
                ST_B: begin
                    if (bvalid) begin
                        bready     <= 1'b0;
                        err_reg    <= b_merged;
                        done_valid <= 1'b1;
                        done_resp  <= b_merged;
                        state      <= ST_IDLE;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

    // Address channels present the captured request; fixed fields only while valid.
    assign awaddr  = addr_reg;
    assign awlen   = len_reg;
    assign awid    = awvalid ? MST_ID : '0;
    assign awsize  = awvalid ? AXSIZE : 3'd0;
    assign awburst = awvalid ? BURST_INCR : 2'b00;

    assign araddr  = addr_reg;
    assign arlen   = len_reg;
    assign arid    = arvalid ? MST_ID : '0;
    assign arsize  = arvalid ? AXSIZE : 3'd0;
    assign arburst = arvalid ? BURST_INCR : 2'b00;

    // Read data passes straight through to the core while in the R phase.
    assign rready   = (state == ST_R) && rd_ready;
    assign rd_valid = (state == ST_R) && rvalid;
    assign rd_data  = (state == ST_R) ? rdata : '0;
    assign rd_last  = (state == ST_R) && rlast;

    // Write data passes straight through to the slave while in the W phase.
    assign wvalid   = (state == ST_W) && wd_valid;
    assign wd_ready = (state == ST_W) && wready;
    assign wdata    = (state == ST_W) ? wd_data : '0;
    assign wstrb    = (state == ST_W) ? wd_strb : '0;
    assign wlast    = (state == ST_W) && is_last;

endmodule
